// File: rtl/fetch_unit.sv
// Instruction fetch stage: one outstanding imem request, a one-entry hold
// buffer for decode stalls, and squash of wrong-path fetches on redirect.
module fetch_unit #(
  parameter logic [0:31] RESET_PC = 32'h80020000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        redirect,
  input  logic [0:31] redirect_pc,
  output logic        imem_req,
  output logic [0:31] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [0:31] imem_rdata,
  output logic [0:31] insn,
  output logic [0:31] pc,
  output logic        valid_insn
);

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD} state_t;

  typedef struct packed {
    logic [0:31] insn;
    logic [0:31] pc;
  } slot_t;

  state_t      state_q, state_d;
  logic [0:31] fpc_q, fpc_d;
  logic        kill_q, kill_d;
  slot_t       hbuf_q, hbuf_d;
  slot_t       out_q, out_d;
  logic        vld_q, vld_d;

  logic        load;
  slot_t       load_val;
  logic [0:31] tgt;
  logic [0:31] fpc_inc;
  logic        slot_free;
  logic        consumed;

  // Targets are word aligned; low two address bits are dropped.
  assign tgt       = {redirect_pc[0:29], 2'b00};
  assign fpc_inc   = fpc_q + 32'd4;
  assign slot_free = !vld_q || !stall;
  assign consumed  = vld_q && !stall;

  always_comb begin
    state_d  = state_q;
    fpc_d    = fpc_q;
    kill_d   = kill_q;
    hbuf_d   = hbuf_q;
    out_d    = out_q;
    vld_d    = vld_q;
    load     = 1'b0;
    load_val = '0;

    if (consumed) vld_d = 1'b0;

    unique case (state_q)
      S_REQ: begin
        if (redirect) fpc_d = tgt;
        if (imem_gnt) begin
          state_d = S_WAIT;
          // A grant racing a redirect fetched the old path; drop its reply.
          kill_d  = redirect;
        end
      end
      S_WAIT: begin
        if (redirect) fpc_d = tgt;
        if (imem_rvalid) begin
          if (kill_q || redirect) begin
            kill_d  = 1'b0;
            state_d = S_REQ;
          end else if (slot_free) begin
            load     = 1'b1;
            load_val = '{insn: imem_rdata, pc: fpc_q};
            fpc_d    = fpc_inc;
            state_d  = S_REQ;
          end else begin
            hbuf_d  = '{insn: imem_rdata, pc: fpc_q};
            state_d = S_HOLD;
          end
        end else if (redirect) begin
          kill_d = 1'b1;
        end
      end
      S_HOLD: begin
        if (redirect) begin
          fpc_d   = tgt;
          hbuf_d  = '0;
          state_d = S_REQ;
        end else if (!stall) begin
          load     = 1'b1;
          load_val = hbuf_q;
          fpc_d    = fpc_inc;
          state_d  = S_REQ;
        end
      end
      default: state_d = S_REQ;
    endcase

    if (load) begin
      out_d = load_val;
      vld_d = 1'b1;
    end
    // Flush wins over any load in the same cycle.
    if (redirect) vld_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_REQ;
      fpc_q       <= RESET_PC;
      kill_q      <= 1'b0;
      hbuf_q      <= '0;
      out_q.insn  <= '0;
      out_q.pc    <= RESET_PC;
      vld_q       <= 1'b0;
    end else begin
      state_q <= state_d;
      fpc_q   <= fpc_d;
      kill_q  <= kill_d;
      hbuf_q  <= hbuf_d;
      out_q   <= out_d;
      vld_q   <= vld_d;
    end
  end

  assign imem_req   = (state_q == S_REQ) && rst_n;
  assign imem_addr  = fpc_q;
  assign insn       = out_q.insn;
  assign pc         = out_q.pc;
  assign valid_insn = vld_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: imem responder model plus an expected-pc scoreboard.
module tb_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h80020000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall, redirect;
  logic [0:31] redirect_pc;
  logic        imem_req, imem_gnt, imem_rvalid;
  logic [0:31] imem_addr, imem_rdata;
  logic [0:31] insn, pc;
  logic        valid_insn;

  logic        gnt_en = 1'b0;
  logic        inj = 1'b0;
  int          lat = 1;
  logic        rv1 = 1'b0, rv2 = 1'b0;
  logic [31:0] a1 = '0, a2 = '0;

  logic [31:0] exp_q[$];
  int          n_chk = 0;
  int          n_fail = 0;

  fetch_unit dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .insn(insn), .pc(pc), .valid_insn(valid_insn)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rd_fn(input logic [31:0] a);
    return a ^ 32'h5A5AA5A5;
  endfunction

  // Memory: grants when enabled, answers 1 or 2 cycles after the grant.
  assign imem_gnt    = gnt_en & imem_req;
  assign imem_rvalid = inj | ((lat == 2) ? rv2 : rv1);
  assign imem_rdata  = inj ? 32'hDEADBEEF : rd_fn((lat == 2) ? a2 : a1);

  always @(posedge clk) begin
    rv1 <= imem_req & imem_gnt;
    a1  <= imem_addr;
    rv2 <= rv1;
    a2  <= a1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "bench time limit");
  end

  // Drive inputs for the next edge at a negedge; report whether the
  // currently presented instruction will be consumed.
  task automatic step(input logic st, input logic rd, input logic [31:0] rpc,
                      output logic got);
    @(negedge clk);
    stall       = st;
    redirect    = rd;
    redirect_pc = rpc;
    got         = valid_insn && !st && !rd;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
    gnt_en = 1'b0; inj = 1'b0; lat = 1;
    exp_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
    gnt_en = 1'b0; inj = 1'b0;
    @(negedge clk);
    n_chk++; if (valid_insn !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", valid_insn); end
    n_chk++; if (insn !== 32'h0) begin n_fail++; $display("FAIL reset_insn: got %h want 0", insn); end
    n_chk++; if (pc !== RST_PC) begin n_fail++; $display("FAIL reset_pc: got %h want %h", pc, RST_PC); end
    n_chk++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b want 0", imem_req); end
    n_chk++; if (imem_addr !== RST_PC) begin n_fail++; $display("FAIL reset_addr: got %h want %h", imem_addr, RST_PC); end
    rst_n = 1'b1;
    @(negedge clk);
    n_chk++;
    if (imem_req !== 1'b1 || imem_addr !== RST_PC || valid_insn !== 1'b0) begin
      n_fail++;
      $display("FAIL post_reset_req: req=%b addr=%h valid=%b want 1 %h 0", imem_req, imem_addr, valid_insn, RST_PC);
    end
  endtask

  task automatic test_sequential();
    logic got;
    logic [31:0] e;
    int ndel;
    apply_reset();
    gnt_en = 1'b1;
    ndel = 0;
    for (int i = 0; i < 3; i++) exp_q.push_back(RST_PC + 32'(4 * i));
    for (int k = 1; k <= 40 && exp_q.size() != 0; k++) begin
      step(1'b0, 1'b0, 32'h0, got);
      if (got) begin
        n_chk++;
        e = exp_q.pop_front();
        if (pc !== e || insn !== rd_fn(e)) begin
          n_fail++;
          $display("FAIL seq_data: pc=%h insn=%h want pc=%h insn=%h", pc, insn, e, rd_fn(e));
        end
        n_chk++;
        if (k != 2 * (ndel + 1)) begin
          n_fail++;
          $display("FAIL seq_latency: delivered at step %0d want step %0d", k, 2 * (ndel + 1));
        end
        ndel++;
      end
    end
    n_chk++;
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL seq_timeout: %0d left want 0", exp_q.size()); end
  endtask

  task automatic test_stall();
    logic got;
    logic [31:0] e;
    apply_reset();
    gnt_en = 1'b1;
    for (int i = 0; i < 4; i++) exp_q.push_back(RST_PC + 32'(4 * i));
    for (int k = 1; k <= 40 && exp_q.size() != 0; k++) begin
      step(k >= 4 && k <= 8, 1'b0, 32'h0, got);
      if (k >= 4 && k <= 8) begin
        n_chk++;
        if (valid_insn !== 1'b1 || pc !== 32'h80020004) begin
          n_fail++;
          $display("FAIL stall_hold step %0d: valid=%b pc=%h want 1 80020004", k, valid_insn, pc);
        end
      end
      if (k >= 6 && k <= 8) begin
        n_chk++;
        if (imem_req !== 1'b0) begin n_fail++; $display("FAIL stall_noreq step %0d: req=%b want 0", k, imem_req); end
      end
      if (k == 10) begin
        n_chk++;
        if (valid_insn !== 1'b1 || pc !== 32'h80020008) begin
          n_fail++;
          $display("FAIL stall_release: valid=%b pc=%h want 1 80020008", valid_insn, pc);
        end
      end
      if (got) begin
        n_chk++;
        if (exp_q.size() == 0) begin
          n_fail++; $display("FAIL stall_extra: pc=%h want none", pc);
        end else begin
          e = exp_q.pop_front();
          if (pc !== e || insn !== rd_fn(e)) begin
            n_fail++;
            $display("FAIL stall_data: pc=%h insn=%h want pc=%h insn=%h", pc, insn, e, rd_fn(e));
          end
        end
      end
    end
    n_chk++;
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL stall_timeout: %0d left want 0", exp_q.size()); end
  endtask

  // mode 0: WAIT, late reply; 1: WAIT, reply same cycle; 2: with grant;
  // 3: in HOLD under stall; 4: unaligned target near the top of memory.
  task automatic test_redirect(input int mode);
    logic got, seen;
    logic [31:0] rpc, tgt, e;
    int rk;
    apply_reset();
    lat = (mode == 0) ? 2 : 1;
    case (mode)
      0, 1:    begin rpc = 32'h00400010; tgt = 32'h00400010; rk = 1; end
      2:       begin rpc = 32'h00400013; tgt = 32'h00400010; rk = 2; end
      3:       begin rpc = 32'h00400020; tgt = 32'h00400020; rk = 7; end
      default: begin rpc = 32'hFFFFFFF9; tgt = 32'hFFFFFFF8; rk = 1; end
    endcase
    if (mode == 3) exp_q.push_back(RST_PC);
    exp_q.push_back(tgt);
    exp_q.push_back(tgt + 32'd4);
    exp_q.push_back(tgt + 32'd8);
    gnt_en = 1'b1;
    seen = 1'b0;
    for (int k = 1; k <= 60 && exp_q.size() != 0; k++) begin
      step((mode == 3) && k >= 4 && k <= rk, k == rk, rpc, got);
      if (mode == 2 && k == rk) begin
        n_chk++;
        if (imem_req !== 1'b1) begin n_fail++; $display("FAIL redir_gnt_req: req=%b want 1", imem_req); end
      end
      if (mode == 3 && k == 6) begin
        n_chk++;
        if (imem_req !== 1'b0 || valid_insn !== 1'b1) begin
          n_fail++; $display("FAIL redir_hold_pre: req=%b valid=%b want 0 1", imem_req, valid_insn);
        end
      end
      if (k == rk + 1) begin
        n_chk++;
        if (valid_insn !== 1'b0) begin n_fail++; $display("FAIL redir_flush m%0d: valid=%b want 0", mode, valid_insn); end
      end
      if (k > rk && !seen && imem_req === 1'b1) begin
        seen = 1'b1;
        n_chk++;
        if (imem_addr !== tgt) begin n_fail++; $display("FAIL redir_addr m%0d: addr=%h want %h", mode, imem_addr, tgt); end
      end
      if (got) begin
        n_chk++;
        if (exp_q.size() == 0) begin
          n_fail++; $display("FAIL redir_extra m%0d: pc=%h want none", mode, pc);
        end else begin
          e = exp_q.pop_front();
          if (pc !== e || insn !== rd_fn(e)) begin
            n_fail++;
            $display("FAIL redir_data m%0d: pc=%h insn=%h want pc=%h insn=%h", mode, pc, insn, e, rd_fn(e));
          end
        end
      end
    end
    n_chk++;
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL redir_timeout m%0d: %0d left want 0", mode, exp_q.size()); end
  endtask

  task automatic test_reset_mid();
    logic got;
    logic [31:0] e;
    apply_reset();
    gnt_en = 1'b1;
    exp_q.push_back(RST_PC);
    for (int k = 1; k <= 5; k++) begin
      step(k >= 4, 1'b0, 32'h0, got);
      if (got) begin
        n_chk++;
        e = exp_q.pop_front();
        if (pc !== e) begin n_fail++; $display("FAIL mid_pre_data: pc=%h want %h", pc, e); end
      end
    end
    n_chk++;
    if (valid_insn !== 1'b1 || pc !== 32'h80020004 || imem_req !== 1'b0) begin
      n_fail++; $display("FAIL mid_pre_state: valid=%b pc=%h req=%b want 1 80020004 0", valid_insn, pc, imem_req);
    end
    #2 rst_n = 1'b0;
    stall = 1'b0;
    #1;
    n_chk++;
    if (valid_insn !== 1'b0 || insn !== 32'h0 || pc !== RST_PC || imem_req !== 1'b0 || imem_addr !== RST_PC) begin
      n_fail++;
      $display("FAIL mid_async: valid=%b insn=%h pc=%h req=%b addr=%h want 0 0 %h 0 %h",
               valid_insn, insn, pc, imem_req, imem_addr, RST_PC, RST_PC);
    end
    @(negedge clk);
    rst_n = 1'b1; gnt_en = 1'b0; inj = 1'b1;
    @(negedge clk);
    inj = 1'b0; gnt_en = 1'b1;
    n_chk++;
    if (valid_insn !== 1'b0 || imem_req !== 1'b1 || imem_addr !== RST_PC) begin
      n_fail++;
      $display("FAIL mid_late_rvalid: valid=%b req=%b addr=%h want 0 1 %h", valid_insn, imem_req, imem_addr, RST_PC);
    end
    exp_q.delete();
    exp_q.push_back(RST_PC);
    exp_q.push_back(RST_PC + 32'd4);
    for (int k = 1; k <= 30 && exp_q.size() != 0; k++) begin
      step(1'b0, 1'b0, 32'h0, got);
      if (got) begin
        n_chk++;
        e = exp_q.pop_front();
        if (pc !== e || insn !== rd_fn(e)) begin
          n_fail++;
          $display("FAIL mid_restart: pc=%h insn=%h want pc=%h insn=%h", pc, insn, e, rd_fn(e));
        end
      end
    end
    n_chk++;
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL mid_timeout: %0d left want 0", exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_stall();
    for (int m = 0; m < 5; m++) test_redirect(m);
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
